// File: rtl/rom_uart_loader_if.sv
// ROM write port and boot status bundle driven by rom_uart_loader.
// The loader owns the master side; the ROM and SoC glue consume the slave side.
interface rom_uart_loader_if #(
  parameter int ADDR_W = 12
);
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output rom_we, rom_waddr, rom_wdata, cpu_rst_n, busy, done, err
  );

  modport slave (
    input rom_we, rom_waddr, rom_wdata, cpu_rst_n, busy, done, err
  );
endinterface

// File: rtl/rom_uart_loader.sv
// UART (8N1) boot loader: receives a framed, XOR-checked image and writes it word by
// word into the instruction ROM, releasing the CPU from reset only after a good image.
module rom_uart_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_W       = 12,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  rom_uart_loader_if.master bus
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_L,
    ST_CNT_H,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Synchronizer flops reset to the idle-high line level so reset never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    rx_state_d   = rx_state_q;
    baud_cnt_d   = baud_cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (rx_state_q)
      RX_IDLE: begin
        baud_cnt_d = '0;
        if (rx_prev_q && !rx_s_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == FULL_LAST) begin
          baud_cnt_d = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (baud_cnt_q == FULL_LAST) begin
          baud_cnt_d   = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_s_q;
          frame_err_d  = !rx_s_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame parser and ROM writer
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       words_rem_q, words_rem_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_waddr_q, rom_waddr_d;
  logic [31:0]       rom_wdata_q, rom_wdata_d;
  logic [15:0]       n_words;
  logic              in_frame;

  assign in_frame = (state_q == ST_CNT_L) || (state_q == ST_CNT_H) ||
                    (state_q == ST_DATA)  || (state_q == ST_CSUM);

  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    words_rem_d = words_rem_q;
    byte_idx_d  = byte_idx_q;
    csum_d      = csum_q;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr_q;
    rom_wdata_d = rom_wdata_q;
    n_words     = {rx_shift_q, cnt_lo_q};

    // The last word's pulse happens after leaving DATA, so the address never steps past it.
    if (rom_we_q && state_q == ST_DATA) rom_waddr_d = rom_waddr_q + ADDR_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (byte_valid_q && rx_shift_q == SYNC_BYTE) begin
          state_d = ST_CNT_L;
          csum_d  = '0;
        end
      end
      ST_CNT_L: begin
        if (byte_valid_q) begin
          cnt_lo_d = rx_shift_q;
          csum_d   = csum_q ^ rx_shift_q;
          state_d  = ST_CNT_H;
        end
      end
      ST_CNT_H: begin
        if (byte_valid_q) begin
          csum_d      = csum_q ^ rx_shift_q;
          words_rem_d = n_words;
          byte_idx_d  = '0;
          if ({1'b0, n_words} > MAX_WORDS) state_d = ST_ERROR;
          else if (n_words == 16'd0)       state_d = ST_CSUM;
          else                             state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_valid_q) begin
          rom_wdata_d[{byte_idx_q, 3'b000} +: 8] = rx_shift_q;
          csum_d     = csum_q ^ rx_shift_q;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            rom_we_d    = 1'b1;
            words_rem_d = words_rem_q - 16'd1;
            if (words_rem_q == 16'd1) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (byte_valid_q) state_d = (rx_shift_q == csum_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: state_d = state_q;
      default: state_d = ST_IDLE;
    endcase

    // A bad stop bit only matters once a frame has started.
    if (frame_err_q && in_frame) state_d = ST_ERROR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_lo_q    <= '0;
      words_rem_q <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      words_rem_q <= words_rem_d;
      byte_idx_q  <= byte_idx_d;
      csum_q      <= csum_d;
      rom_we_q    <= rom_we_d;
      rom_waddr_q <= rom_waddr_d;
      rom_wdata_q <= rom_wdata_d;
    end
  end

  assign bus.rom_we    = rom_we_q;
  assign bus.rom_waddr = rom_waddr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.busy      = in_frame;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = (state_q == ST_ERROR);
  assign bus.cpu_rst_n = (state_q == ST_DONE);

endmodule

// File: doc/rom_uart_loader.md
Name: rom_uart_loader

Overview:
Hardware boot loader that fills the SoC instruction ROM over a UART serial link, replacing simulation-only memory preload. It receives a framed program image (8N1), assembles little-endian 32-bit words, writes them sequentially into the ROM write port, and holds the CPU in reset until the image is complete and its checksum verifies. It sits between the board UART pin and the ROM write port/CPU reset inside the SoC top.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4
ADDR_W, 12, ROM word-address width; max image = 2^ADDR_W words
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
uart_rx  input  1  serial input, idle high, asynchronous to clk
rom_we  output  1  ROM write strobe, one-cycle pulse per word
rom_waddr  output  ADDR_W  ROM word address of the current write
rom_wdata  output  32  ROM write data
cpu_rst_n  output  1  CPU reset, low = CPU held in reset
busy  output  1  frame in progress
done  output  1  image loaded and verified (sticky)
err  output  1  framing/checksum/size error (sticky)

Behaviour:
- Reset values: rom_we=0, rom_waddr=0, rom_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0; FSM=IDLE; rx engine idle. Reset is asynchronous and active-high: it clears state at any time, mid-byte or mid-frame included; partially written ROM contents are not rolled back.
- RX engine: 2-flop synchronizer on uart_rx. A falling edge starts a bit counter. The start bit is resampled at CLKS_PER_BIT/2; if it reads high, treat it as a glitch and return to idle with no byte and no error. Sample 8 data bits LSB-first, then the stop bit, each at full CLKS_PER_BIT intervals. A valid stop bit produces a one-cycle byte_valid pulse. A stop bit of 0 is a framing error, which is ignored in IDLE and latches err in any other state.
- Frame format: SYNC_BYTE, CNT_L, CNT_H (16-bit word count N, little endian), then N x 4 data bytes (each word LSB byte first), then CSUM = XOR of every byte from CNT_L through the last data byte.
- FSM states: IDLE -> CNT_L -> CNT_H -> DATA -> CSUM -> DONE; any -> ERROR.
- IDLE: non-sync bytes are discarded. SYNC_BYTE enters CNT_L and sets busy=1.
- CNT_H: if N > 2^ADDR_W, go to ERROR with no writes. If N = 0, go to CSUM. Otherwise go to DATA.
- DATA: a 2-bit byte index shifts bytes into rom_wdata[8*i+:8]. On the cycle after the 4th byte_valid, rom_we=1 for exactly one cycle with rom_waddr/rom_wdata stable. rom_waddr increments the cycle after the pulse. After the Nth write, go to CSUM. The address never wraps, given the N check.
- CSUM: on a match, go to DONE. On a mismatch, go to ERROR.
- DONE: busy=0, done=1, cpu_rst_n=1 from the cycle after the checksum byte_valid. All further RX input is ignored until rst.
- ERROR: busy=0, err=1, cpu_rst_n stays 0, done stays 0. Sticky until rst.
- done and err are never both 1.

Test Plan:
1. CLKS_PER_BIT=8; send A5 02 00 13 00 00 00 93 0D 10 00 9F -> two rom_we pulses: (addr 0, 32'h00000013) and (addr 1, 32'h00100D93); then done=1, cpu_rst_n=1, busy=0, err=0.
2. Send 00 FF 5A, then the frame from case 1 -> leading bytes ignored; same writes and done as case 1.
3. Frame from case 1 with checksum 9E -> both writes occur, then err=1, done=0, cpu_rst_n=0; later bytes are ignored.
4. Stop bit forced to 0 on the third data byte -> err=1, no rom_we pulses. Separately, a 2-cycle low glitch on idle uart_rx -> no byte received, no err.
5. ADDR_W=4: count 11 00 (N=17) -> err right after CNT_H, zero writes. Count 10 00 (N=16) with a valid image -> 16 writes at addresses 0..15, then done=1.
6. Assert rst during the 2nd word of case 1 -> all outputs return to reset values asynchronously. Resend the full frame -> writes restart at addr 0 and end with done=1.
